// File: rtl/knight_pkg.sv
// Shared definitions for the knight-rider scanner: scan modes, direction
// encoding and the head+tail LED mask builder.
package knight_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_WRAPL  = 2'd1,
    MODE_WRAPR  = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int MAX_W  = 64;
  localparam int MAX_LW = 6;

  // Tail trails behind the motion; out-of-range tail bits clip or wrap.
  function automatic logic [MAX_W-1:0] pattern(input int p, input logic d,
                                               input int w, input int t,
                                               input logic wrap);
    logic [MAX_W-1:0] m;
    int idx;
    m = '0;
    idx = p;
    m[idx[MAX_LW-1:0]] = 1'b1;
    for (int k = 1; k < MAX_W; k++) begin
      if (k <= t) begin
        idx = d ? p + k : p - k;
        if (idx >= 0 && idx < w) begin
          m[idx[MAX_LW-1:0]] = 1'b1;
        end else if (wrap) begin
          idx = d ? idx - w : idx + w;
          m[idx[MAX_LW-1:0]] = 1'b1;
        end
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/knight_prescale.sv
// Step prescaler: fires once every div+1 enabled cycles. The >= compare lets a
// lowered div take effect immediately instead of waiting for a counter wrap.
module knight_prescale #(
  parameter int DIV_W = 4
) (
  input  logic             ck,
  input  logic             res,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;

  assign tick = en & (cnt_reg >= div);

  always_ff @(posedge ck) begin
    if (res) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/knight_scan.sv
// Parametrised knight-rider LED scanner with bounce/wrap/freeze modes,
// trailing tail, end-point dwell and step/turn status pulses.
module knight_scan
  import knight_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4,
  parameter int TAIL  = 0,
  parameter int DWELL = 0
) (
  input  logic                     ck,
  input  logic                     res,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [DIV_W-1:0]         div,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     dir,
  output logic                     step,
  output logic                     turn
);

  localparam int PW  = $clog2(WIDTH);
  localparam int DCW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > MAX_W || TAIL < 0 || TAIL >= WIDTH || DWELL < 0) begin : g_param_check
    $error("knight_scan: illegal WIDTH/TAIL/DWELL combination");
  end

  logic             run;
  logic             tick;
  logic [PW-1:0]    pos_reg, pos_next;
  dir_t             dir_reg, dir_next;
  logic [DCW-1:0]   dcnt_reg, dcnt_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             step_reg;
  logic             turn_reg, turn_next;
  logic             wrap;

  assign run = en & (mode != MODE_FREEZE);

  knight_prescale #(.DIV_W(DIV_W)) u_prescale (
    .ck   (ck),
    .res  (res),
    .en   (run),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    pos_next  = pos_reg;
    dir_next  = dir_reg;
    dcnt_next = dcnt_reg;
    turn_next = 1'b0;
    wrap      = 1'b0;
    if (tick) begin
      case (mode)
        MODE_BOUNCE: begin
          if (dir_reg == DIR_UP) begin
            if (pos_reg == LAST) begin
              if (int'(dcnt_reg) < DWELL) begin
                dcnt_next = dcnt_reg + DCW'(1);
              end else begin
                pos_next  = LAST - PW'(1);
                dir_next  = DIR_DOWN;
                dcnt_next = '0;
                turn_next = 1'b1;
              end
            end else begin
              pos_next = pos_reg + PW'(1);
            end
          end else begin
            if (pos_reg == '0) begin
              if (int'(dcnt_reg) < DWELL) begin
                dcnt_next = dcnt_reg + DCW'(1);
              end else begin
                pos_next  = PW'(1);
                dir_next  = DIR_UP;
                dcnt_next = '0;
                turn_next = 1'b1;
              end
            end else begin
              pos_next = pos_reg - PW'(1);
            end
          end
        end
        MODE_WRAPL: begin
          wrap      = 1'b1;
          dir_next  = DIR_UP;
          dcnt_next = '0;
          pos_next  = (pos_reg == LAST) ? '0 : pos_reg + PW'(1);
        end
        MODE_WRAPR: begin
          wrap      = 1'b1;
          dir_next  = DIR_DOWN;
          dcnt_next = '0;
          pos_next  = (pos_reg == '0) ? LAST : pos_reg - PW'(1);
        end
        default: ;
      endcase
    end
    out_next = WIDTH'(pattern(int'(pos_next), dir_next, WIDTH, TAIL, wrap));
  end

  always_ff @(posedge ck) begin
    if (res) begin
      pos_reg  <= '0;
      dir_reg  <= DIR_UP;
      dcnt_reg <= '0;
      out_reg  <= WIDTH'(1);
      step_reg <= 1'b0;
      turn_reg <= 1'b0;
    end else begin
      step_reg <= tick;
      turn_reg <= turn_next;
      if (tick) begin
        pos_reg  <= pos_next;
        dir_reg  <= dir_next;
        dcnt_reg <= dcnt_next;
        out_reg  <= out_next;
      end
    end
  end

  assign out  = out_reg;
  assign pos  = pos_reg;
  assign dir  = dir_reg;
  assign step = step_reg;
  assign turn = turn_reg;

endmodule

// File: tb/tb_knight_scan.sv
// Scoreboard bench: two scanner instances (plain, and tail=2/dwell=1) with
// expected step results queued by the stimulus and checked by monitors.
module tb_knight_scan;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic       a_res = 1'b1, a_en = 1'b1;
  logic [1:0] a_mode = 2'd0;
  logic [3:0] a_div = 4'd0;
  logic [7:0] a_out;
  logic [2:0] a_pos;
  logic       a_dir, a_step, a_turn;

  logic       b_res = 1'b1, b_en = 1'b1;
  logic [1:0] b_mode = 2'd0;
  logic [3:0] b_div = 4'd0;
  logic [7:0] b_out;
  logic [2:0] b_pos;
  logic       b_dir, b_step, b_turn;

  knight_scan #(.WIDTH(8), .DIV_W(4), .TAIL(0), .DWELL(0)) dut_a (
    .ck(ck), .res(a_res), .en(a_en), .mode(a_mode), .div(a_div),
    .out(a_out), .pos(a_pos), .dir(a_dir), .step(a_step), .turn(a_turn)
  );

  knight_scan #(.WIDTH(8), .DIV_W(4), .TAIL(2), .DWELL(1)) dut_b (
    .ck(ck), .res(b_res), .en(b_en), .mode(b_mode), .div(b_div),
    .out(b_out), .pos(b_pos), .dir(b_dir), .step(b_step), .turn(b_turn)
  );

  typedef struct packed {
    logic [7:0] out;
    logic [2:0] pos;
    logic       dir;
    logic       turn;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] bo [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                          8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [2:0] bp [14] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                          3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] o, input logic [2:0] p,
                              input logic d, input logic t);
    exp_t e;
    e = '{out: o, pos: p, dir: d, turn: t};
    return e;
  endfunction

  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  always @(negedge ck) begin
    if (a_step === 1'b1) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_extra_step: got step with out=%0h, expected no step", a_out);
      end else begin
        ea = qa.pop_front();
        chk("a_out", a_out, ea.out);
        chk("a_pos", a_pos, ea.pos);
        chk("a_dir", a_dir, ea.dir);
        chk("a_turn", a_turn, ea.turn);
      end
    end else if (a_turn === 1'b1) begin
      chk("a_turn_without_step", a_turn, 0);
    end
  end

  always @(negedge ck) begin
    if (b_step === 1'b1) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_extra_step: got step with out=%0h, expected no step", b_out);
      end else begin
        eb = qb.pop_front();
        chk("b_out", b_out, eb.out);
        chk("b_pos", b_pos, eb.pos);
        chk("b_dir", b_dir, eb.dir);
        chk("b_turn", b_turn, eb.turn);
      end
    end else if (b_turn === 1'b1) begin
      chk("b_turn_without_step", b_turn, 0);
    end
  end

  initial begin
    // Reset for two cycles with en high.
    cyc();
    cyc();
    chk("reset_out", a_out, 8'h01);
    chk("reset_pos", a_pos, 0);
    chk("reset_dir", a_dir, 0);
    chk("reset_step", a_step, 0);
    chk("reset_turn", a_turn, 0);

    // Bounce, div=0: two full 14-step periods.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 14; i++)
        qa.push_back(mk(bo[i], bp[i], i >= 7, (i == 7) || (p == 1 && i == 0)));
    a_res = 1'b0;
    for (int i = 0; i < 28; i++) begin
      cyc();
      chk("a_step_every_cycle", a_step, 1);
    end

    // div=2: step on every third cycle.
    a_div = 4'd2;
    qa.push_back(mk(8'h02, 3'd1, 1'b0, 1'b1));
    qa.push_back(mk(8'h04, 3'd2, 1'b0, 1'b0));
    qa.push_back(mk(8'h08, 3'd3, 1'b0, 1'b0));
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk("a_div2_step", a_step, (k % 3) == 2);
    end

    // en low mid-count holds counter and pattern.
    cyc();
    chk("a_pre_hold_step", a_step, 0);
    a_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("a_hold_step", a_step, 0);
      chk("a_hold_out", a_out, 8'h08);
      chk("a_hold_pos", a_pos, 3);
    end
    a_en = 1'b1;
    qa.push_back(mk(8'h10, 3'd4, 1'b0, 1'b0));
    cyc();
    chk("a_resume_step0", a_step, 0);
    cyc();
    chk("a_resume_step1", a_step, 1);

    // div lowered from 7 to 1 at cnt=5 fires on the next cycle.
    a_div = 4'd7;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("a_div7_step", a_step, 0);
    end
    a_div = 4'd1;
    qa.push_back(mk(8'h20, 3'd5, 1'b0, 1'b0));
    cyc();
    chk("a_div_lower_step", a_step, 1);

    // Freeze at pos 5, then reset mid-scan.
    a_mode = 2'd3;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("a_freeze_step", a_step, 0);
      chk("a_freeze_pos", a_pos, 5);
      chk("a_freeze_out", a_out, 8'h20);
    end
    a_res = 1'b1;
    cyc();
    chk("a_midreset_pos", a_pos, 0);
    chk("a_midreset_dir", a_dir, 0);
    chk("a_midreset_out", a_out, 8'h01);
    chk("a_midreset_step", a_step, 0);
    chk("a_midreset_turn", a_turn, 0);
    a_res = 1'b0;
    a_mode = 2'd0;
    a_div = 4'd0;
    qa.push_back(mk(8'h02, 3'd1, 1'b0, 1'b0));
    cyc();
    chk("a_post_reset_step", a_step, 1);
    a_en = 1'b0;

    // Tail=2, dwell=1 instance: bounce up to the MSB end.
    chk("b_reset_out", b_out, 8'h01);
    qb.push_back(mk(8'h03, 3'd1, 1'b0, 1'b0));
    qb.push_back(mk(8'h07, 3'd2, 1'b0, 1'b0));
    qb.push_back(mk(8'h0E, 3'd3, 1'b0, 1'b0));
    qb.push_back(mk(8'h1C, 3'd4, 1'b0, 1'b0));
    qb.push_back(mk(8'h38, 3'd5, 1'b0, 1'b0));
    qb.push_back(mk(8'h70, 3'd6, 1'b0, 1'b0));
    qb.push_back(mk(8'hE0, 3'd7, 1'b0, 1'b0));
    qb.push_back(mk(8'hE0, 3'd7, 1'b0, 1'b0));
    qb.push_back(mk(8'hC0, 3'd6, 1'b1, 1'b1));
    b_res = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk("b_step_every_cycle", b_step, 1);
    end

    // Wrap-left through pos 7 -> 0, then wrap-right 0 -> 7.
    b_mode = 2'd1;
    qb.push_back(mk(8'hE0, 3'd7, 1'b0, 1'b0));
    qb.push_back(mk(8'hC1, 3'd0, 1'b0, 1'b0));
    cyc();
    cyc();
    b_mode = 2'd2;
    qb.push_back(mk(8'h83, 3'd7, 1'b1, 1'b0));
    cyc();
    b_en = 1'b0;
    cyc();
    cyc();
    cyc();

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
